// File: rtl/clock_mode_ctrl.sv
// Wall-clock time keeper: BCD hh:mm:ss registers with a RUN / SET_HR / SET_MIN
// mode sequencer, field blink request and a once-per-day rollover pulse.
//
// state   | meaning
// RUN     | time advances on tick, btn_inc ignored, blank held low
// SET_HR  | btn_inc bumps hours only, tick toggles blank
// SET_MIN | btn_inc bumps minutes only, tick toggles blank
module clock_mode_ctrl #(
  parameter bit HOURS_24 = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [1:0] mode,
  output logic       blank,
  output logic       day_out
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  localparam logic [7:0] HR_FIRST = HOURS_24 ? 8'h00 : 8'h01;
  localparam logic [7:0] HR_LAST  = HOURS_24 ? 8'h23 : 8'h12;
  localparam logic [7:0] HR_RST   = HOURS_24 ? 8'h00 : 8'h12;

  state_t     state, state_nxt;
  logic [7:0] hours_nxt, minutes_nxt, seconds_nxt;
  logic       blank_nxt, day_nxt;

  // BCD increment that wraps from 'last' back to 'first'.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] last,
                                         input logic [7:0] first);
    if (v == last)
      return first;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'h0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_nxt   = state;
    hours_nxt   = hours;
    minutes_nxt = minutes;
    seconds_nxt = seconds;
    blank_nxt   = blank;
    day_nxt     = 1'b0;
    case (state)
      RUN: begin
        blank_nxt = 1'b0;
        if (tick) begin
          seconds_nxt = bcd_inc(seconds, 8'h59, 8'h00);
          if (seconds == 8'h59) begin
            minutes_nxt = bcd_inc(minutes, 8'h59, 8'h00);
            if (minutes == 8'h59) begin
              hours_nxt = bcd_inc(hours, HR_LAST, HR_FIRST);
              day_nxt   = (hours == HR_LAST);
            end
          end
        end
        // tick coinciding with btn_mode was applied above before leaving RUN
        if (btn_mode)
          state_nxt = SET_HR;
      end
      SET_HR: begin
        if (btn_mode) begin
          state_nxt = SET_MIN;
          blank_nxt = 1'b0;
        end else if (btn_inc) begin
          hours_nxt = bcd_inc(hours, HR_LAST, HR_FIRST);
          blank_nxt = 1'b0;
        end else if (tick) begin
          blank_nxt = ~blank;
        end
      end
      SET_MIN: begin
        if (btn_mode) begin
          state_nxt   = RUN;
          seconds_nxt = 8'h00;
          blank_nxt   = 1'b0;
        end else if (btn_inc) begin
          minutes_nxt = bcd_inc(minutes, 8'h59, 8'h00);
          blank_nxt   = 1'b0;
        end else if (tick) begin
          blank_nxt = ~blank;
        end
      end
      default: begin
        state_nxt = RUN;
        blank_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      hours   <= HR_RST;
      minutes <= 8'h00;
      seconds <= 8'h00;
      blank   <= 1'b0;
      day_out <= 1'b0;
    end else begin
      state   <= state_nxt;
      hours   <= hours_nxt;
      minutes <= minutes_nxt;
      seconds <= seconds_nxt;
      blank   <= blank_nxt;
      day_out <= day_nxt;
    end
  end

  assign mode = state;

endmodule
